// File: rtl/env_burst_detector.sv
// Hysteresis/debounce burst detector on the unsigned envelope stream.
// Optional feature: define ENV_PEAK_HOLD_EN to report the peak sample of each completed burst.
module env_burst_detector #(
   parameter int DW      = 13,
   parameter int ON_CNT  = 4,
   parameter int OFF_CNT = 8,
   parameter int CW      = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] env_in,
   input  logic          env_valid,
   input  logic [DW-1:0] thr_on,
   input  logic [DW-1:0] thr_off,
   output logic          detect,
   output logic          onset,
   output logic [CW-1:0] event_cnt,
   output logic [CW-1:0] dur_out,
   output logic          dur_valid,
   output logic [DW-1:0] peak_out
);

   localparam int CMAX = (ON_CNT > OFF_CNT) ? ON_CNT : OFF_CNT;
   localparam int NW   = $clog2(CMAX + 1);

   typedef enum logic [1:0] {IDLE, ARM, ACTIVE, RELEASE} state_t;

   state_t        state;
   logic [NW-1:0] cnt;
   logic [NW-1:0] cnt_inc;
   logic [CW-1:0] dur_acc;
   logic [CW-1:0] dur_nxt;
   logic [DW-1:0] thr_eff;
   logic          hi;
   logic          lo;
   logic          start_run;
   logic          burst_end;

   // Release level is clamped to the onset level so a misconfigured pair cannot invert the hysteresis.
   always_comb begin
      thr_eff   = (thr_off < thr_on) ? thr_off : thr_on;
      hi        = (env_in >= thr_on);
      lo        = (env_in < thr_eff);
      cnt_inc   = cnt + 1'b1;
      dur_nxt   = (&dur_acc) ? dur_acc : dur_acc + 1'b1;
      start_run = env_valid && (state == IDLE) && hi;
      burst_end = env_valid && lo &&
                  (((state == ACTIVE) && (OFF_CNT == 1)) ||
                   ((state == RELEASE) && (cnt_inc == NW'(OFF_CNT))));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         detect    <= 1'b0;
         onset     <= 1'b0;
         event_cnt <= '0;
         dur_acc   <= '0;
         dur_out   <= '0;
         dur_valid <= 1'b0;
      end else begin
         onset     <= 1'b0;
         dur_valid <= 1'b0;
         if (env_valid) begin
            case (state)
               IDLE: begin
                  if (hi) begin
                     if (ON_CNT == 1) begin
                        state     <= ACTIVE;
                        cnt       <= '0;
                        detect    <= 1'b1;
                        onset     <= 1'b1;
                        event_cnt <= (&event_cnt) ? event_cnt : event_cnt + 1'b1;
                        dur_acc   <= CW'(ON_CNT);
                     end else begin
                        state <= ARM;
                        cnt   <= NW'(1);
                     end
                  end
               end
               ARM: begin
                  if (!hi) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else if (cnt_inc == NW'(ON_CNT)) begin
                     state     <= ACTIVE;
                     cnt       <= '0;
                     detect    <= 1'b1;
                     onset     <= 1'b1;
                     event_cnt <= (&event_cnt) ? event_cnt : event_cnt + 1'b1;
                     dur_acc   <= CW'(ON_CNT);
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               ACTIVE, RELEASE: begin
                  dur_acc <= dur_nxt;
                  if (burst_end) begin
                     state     <= IDLE;
                     cnt       <= '0;
                     detect    <= 1'b0;
                     dur_out   <= dur_nxt;
                     dur_valid <= 1'b1;
                  end else if (lo) begin
                     state <= RELEASE;
                     cnt   <= (state == ACTIVE) ? NW'(1) : cnt_inc;
                  end else begin
                     state <= ACTIVE;
                     cnt   <= '0;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

`ifdef ENV_PEAK_HOLD_EN
   logic [DW-1:0] peak_run;
   logic [DW-1:0] peak_nxt;

   assign peak_nxt = (env_in > peak_run) ? env_in : peak_run;

   always_ff @(posedge clk) begin
      if (reset) begin
         peak_run <= '0;
         peak_out <= '0;
      end else begin
         if (start_run)
            peak_run <= env_in;
         else if (env_valid && (state != IDLE))
            peak_run <= peak_nxt;
         if (burst_end)
            peak_out <= peak_nxt;
      end
   end
`else
   logic unused_start;
   assign unused_start = start_run;
   assign peak_out     = '0;
`endif

endmodule

// File: tb/tb_env_burst_detector.sv
// Directed self-checking bench for env_burst_detector (ON_CNT=4, OFF_CNT=8).
module tb_env_burst_detector;

   localparam int DW = 13;
   localparam int CW = 16;
`ifdef ENV_PEAK_HOLD_EN
   localparam int PK = 1;
`else
   localparam int PK = 0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] env_in = '0;
   logic          env_valid = 1'b0;
   logic [DW-1:0] thr_on = 13'd1000;
   logic [DW-1:0] thr_off = 13'd600;
   logic          detect;
   logic          onset;
   logic [CW-1:0] event_cnt;
   logic [CW-1:0] dur_out;
   logic          dur_valid;
   logic [DW-1:0] peak_out;

   int n_cmp = 0;
   int n_mis = 0;
   int n_on  = 0;
   int n_dv  = 0;
   int n_lo  = 0;

   always #5 clk = ~clk;

   env_burst_detector #(.DW(DW), .ON_CNT(4), .OFF_CNT(8), .CW(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .env_in    (env_in),
      .env_valid (env_valid),
      .thr_on    (thr_on),
      .thr_off   (thr_off),
      .detect    (detect),
      .onset     (onset),
      .event_cnt (event_cnt),
      .dur_out   (dur_out),
      .dur_valid (dur_valid),
      .peak_out  (peak_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      n_on = 0;
      n_dv = 0;
      n_lo = 0;
   endtask

   // One sample per clock; outputs sampled 1 ns after the edge.
   task automatic feed(input logic [DW-1:0] v, input int n, input logic vld = 1'b1);
      for (int i = 0; i < n; i++) begin
         env_in    = v;
         env_valid = vld;
         @(posedge clk);
         #1;
         n_on += int'(onset);
         n_dv += int'(dur_valid);
         if (!detect) n_lo++;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_detect", detect, 0);
      check("rst_onset", onset, 0);
      check("rst_event", event_cnt, 0);
      check("rst_dur", dur_out, 0);
      check("rst_dv", dur_valid, 0);
      check("rst_peak", peak_out, 0);
      reset = 1'b0;

      // short run: 3 hi then lo never declares
      clr();
      feed(1200, 3);
      feed(500, 1);
      check("short_onset", n_on, 0);
      check("short_detect", n_lo, 4);

      // full burst: 20x1200 then 10x500
      clr();
      feed(1200, 3);
      check("b1_pre_onset", onset, 0);
      feed(1200, 1);
      check("b1_onset", onset, 1);
      check("b1_detect", detect, 1);
      check("b1_event", event_cnt, 1);
      feed(1200, 1);
      check("b1_onset_pulse", onset, 0);
      feed(1200, 15);
      feed(500, 7);
      check("b1_hold_detect", detect, 1);
      check("b1_no_dv_early", n_dv, 0);
      feed(500, 1);
      check("b1_end_detect", detect, 0);
      check("b1_end_dv", dur_valid, 1);
      check("b1_dur", dur_out, 28);
      check("b1_peak", peak_out, 1200 * PK);
      feed(500, 2);
      check("b1_dv_once", n_dv, 1);
      check("b1_onset_once", n_on, 1);

      // hysteresis: 800 sits between thresholds, partial release re-enters ACTIVE
      clr();
      feed(1200, 4);
      check("hy_event", event_cnt, 2);
      feed(800, 50);
      feed(500, 5);
      feed(700, 1);
      feed(500, 7);
      check("hy_detect_held", n_lo, 3);
      check("hy_no_dv", n_dv, 0);
      feed(500, 1);
      check("hy_end_dv", dur_valid, 1);
      check("hy_dur", dur_out, 68);
      check("hy_onsets", n_on, 1);

      // valid gating: invalid cycles carry values that would disturb state if counted
      clr();
      for (int k = 0; k < 3; k++) begin
         feed(1200, 1);
         feed(0, 1, 1'b0);
      end
      check("vg_no_onset", n_on, 0);
      check("vg_detect_low", detect, 0);
      feed(1200, 1);
      check("vg_onset", onset, 1);
      feed(0, 1, 1'b0);
      check("vg_onset_pulse", onset, 0);
      check("vg_detect", detect, 1);
      for (int k = 0; k < 4; k++) begin
         feed(1200, 1);
         feed(0, 1, 1'b0);
      end
      for (int k = 0; k < 8; k++) begin
         feed(500, 1);
         feed(1200, 1, 1'b0);
      end
      check("vg_dv", n_dv, 1);
      check("vg_dur", dur_out, 16);
      check("vg_detect_end", detect, 0);
      check("vg_event", event_cnt, 3);

      // thr_off above thr_on: release level clamps to thr_on
      clr();
      thr_off = 13'd1500;
      feed(1200, 7);
      check("cl_detect", detect, 1);
      feed(900, 8);
      check("cl_dv", n_dv, 1);
      check("cl_dur", dur_out, 15);
      check("cl_event", event_cnt, 4);

      // peak capture
      feed(1200, 4);
      feed(4095, 1);
      feed(1200, 2);
      feed(900, 8);
      check("pk_dur", dur_out, 15);
      check("pk_peak", peak_out, 4095 * PK);
      check("pk_event", event_cnt, 5);

      // reset mid-burst aborts without a duration report
      clr();
      feed(1200, 5);
      check("rm_detect", detect, 1);
      reset = 1'b1;
      feed(500, 1);
      check("rm_detect0", detect, 0);
      check("rm_event0", event_cnt, 0);
      check("rm_dur0", dur_out, 0);
      check("rm_dv0", dur_valid, 0);
      check("rm_peak0", peak_out, 0);
      reset = 1'b0;
      clr();
      feed(500, 8);
      check("rm_no_dv", n_dv, 0);

      // thr_on=0: every sample hi, release impossible
      clr();
      thr_on  = 13'd0;
      thr_off = 13'd600;
      feed(0, 4);
      check("z_onset", n_on, 1);
      check("z_event", event_cnt, 1);
      clr();
      feed(0, 20);
      check("z_detect_held", n_lo, 0);
      check("z_no_dv", n_dv, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
